// File: rtl/multi_ch_clk_divider.sv
// rtl/multi_ch_clk_divider.sv - NUM_CH programmable clock divider with shadowed config and phase-align sync
// Optional macro DIVIDER_TICK_EN adds o_tick, a one-cycle pulse at the first cycle of every period.
module multi_ch_clk_divider #(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = 16,
  parameter int  DEF_DIV  = 16,
  parameter int  DEF_DUTY = 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  input  logic [CNT_W-1:0]  i_cfg_duty,
  output logic [NUM_CH-1:0] o_clk_div,
`ifdef DIVIDER_TICK_EN
  output logic [NUM_CH-1:0] o_tick,
`endif
  output logic [NUM_CH-1:0] o_cfg_pending
);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [CNT_W-1:0]  div_sh_q   [NUM_CH];
  logic [CNT_W-1:0]  div_sh_d   [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d  [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] wr;

  // Out-of-range channel numbers never match any index, so such writes fall away.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr[c] = i_cfg_we && (i_cfg_ch == CH_W'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]      = cnt_q[c];
      div_act_d[c]  = div_act_q[c];
      duty_act_d[c] = duty_act_q[c];
      div_sh_d[c]   = div_sh_q[c];
      duty_sh_d[c]  = duty_sh_q[c];
      run_d[c]      = run_q[c];
      pend_d[c]     = pend_q[c];
      out_d[c]      = out_q[c];

      if (!run_q[c]) begin
        // Idle channel: config takes effect at once and a start uses the fresh values.
        if (wr[c]) begin
          div_act_d[c]  = i_cfg_div;
          duty_act_d[c] = i_cfg_duty;
          div_sh_d[c]   = i_cfg_div;
          duty_sh_d[c]  = i_cfg_duty;
          pend_d[c]     = 1'b0;
        end
        cnt_d[c] = '0;
        run_d[c] = i_en[c] && (div_act_d[c] != '0);
        out_d[c] = run_d[c] && (duty_act_d[c] != '0);
      end else if (!i_en[c]) begin
        if (wr[c]) begin
          div_sh_d[c]  = i_cfg_div;
          duty_sh_d[c] = i_cfg_duty;
          pend_d[c]    = 1'b1;
        end
        cnt_d[c] = '0;
        run_d[c] = 1'b0;
        out_d[c] = 1'b0;
      end else if (i_sync || (cnt_q[c] == div_act_q[c] - CNT_W'(1))) begin
        if (wr[c]) begin
          div_act_d[c]  = i_cfg_div;
          duty_act_d[c] = i_cfg_duty;
          div_sh_d[c]   = i_cfg_div;
          duty_sh_d[c]  = i_cfg_duty;
          pend_d[c]     = 1'b0;
        end else if (pend_q[c]) begin
          div_act_d[c]  = div_sh_q[c];
          duty_act_d[c] = duty_sh_q[c];
          pend_d[c]     = 1'b0;
        end
        // A zero divisor loaded here parks the channel exactly like a disable.
        cnt_d[c] = '0;
        run_d[c] = (div_act_d[c] != '0);
        out_d[c] = run_d[c] && (duty_act_d[c] != '0);
      end else begin
        if (wr[c]) begin
          div_sh_d[c]  = i_cfg_div;
          duty_sh_d[c] = i_cfg_duty;
          pend_d[c]    = 1'b1;
        end
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        out_d[c] = (cnt_d[c] < duty_act_q[c]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]      <= '0;
        div_act_q[c]  <= CNT_W'(DEF_DIV);
        duty_act_q[c] <= CNT_W'(DEF_DUTY);
        div_sh_q[c]   <= CNT_W'(DEF_DIV);
        duty_sh_q[c]  <= CNT_W'(DEF_DUTY);
      end
      run_q  <= '0;
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]      <= cnt_d[c];
        div_act_q[c]  <= div_act_d[c];
        duty_act_q[c] <= duty_act_d[c];
        div_sh_q[c]   <= div_sh_d[c];
        duty_sh_q[c]  <= duty_sh_d[c];
      end
      run_q  <= run_d;
      pend_q <= pend_d;
      out_q  <= out_d;
    end
  end

  assign o_clk_div     = out_q;
  assign o_cfg_pending = pend_q;

`ifdef DIVIDER_TICK_EN
  // The counter only returns to zero on a start, boundary or sync, so that marks a period's first cycle.
  logic [NUM_CH-1:0] tick_q, tick_d;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tick_d[c] = run_d[c] && (cnt_d[c] == '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;
`endif

endmodule

// File: doc/multi_ch_clk_divider.md
Name: multi_ch_clk_divider

Overview:
- Parametrised successor of the team's single-channel fixed clock divider.
- NUM_CH independent divided-clock outputs from one source clock.
- Each channel has its divisor and high time programmable at run time, a per-channel enable, and a global phase-align pulse.
- Config updates are shadowed and applied only at a period boundary, so outputs never glitch. Sits between the board clock and the slow peripheral/LED/scan logic.

Parameters:
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 16, width of divisor, duty and internal counters
- DEF_DIV, 16, divisor loaded into every channel at reset
- DEF_DUTY, 4, high-cycle count loaded into every channel at reset

Ports:
- i_clk  in  1  source clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  NUM_CH  per-channel enable
- i_sync  in  1  single-cycle pulse, restarts all enabled channels at phase 0
- i_cfg_we  in  1  config write strobe
- i_cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of write
- i_cfg_div  in  CNT_W  new divisor (period in i_clk cycles)
- i_cfg_duty  in  CNT_W  new high time in i_clk cycles
- o_clk_div  out  NUM_CH  divided clock outputs, registered
- o_cfg_pending  out  NUM_CH  shadow config written but not yet applied

Behaviour:
- Reset: o_clk_div=0, o_cfg_pending=0, all counters 0, active and shadow div/duty = DEF_DIV/DEF_DUTY. Reset is asynchronous and dominates everything, including mid-period.
- Per channel state: cnt, div_act, duty_act, div_sh, duty_sh, running flag.
- Period: div_act cycles. o_clk_div is high for the first min(duty_act, div_act) cycles, then low.
  - duty_act=0: constant low.
  - duty_act>=div_act: constant high.
  - div_act=0: channel behaves as disabled, output low.
- Start: on the edge where i_en[ch]=1 and the channel is not running: cnt<=0, running<=1, o_clk_div[ch]<=(duty_act>0). Output is valid in the next cycle. Zero extra latency beyond that register.
- Run: each edge, cnt <= (cnt==div_act-1) ? 0 : cnt+1, and o_clk_div[ch] <= (cnt_next < duty_act).
- Disable: on the edge where i_en[ch]=0: cnt<=0, running<=0, o_clk_div[ch]<=0. This is immediate, mid-period allowed.
- Boundary = running && cnt==div_act-1. At a boundary with pending set: div_act<=div_sh, duty_act<=duty_sh, pending<=0. The next period uses the new values.
- Config write: if i_cfg_we and i_cfg_ch<NUM_CH: div_sh/duty_sh <= i_cfg_div/i_cfg_duty and pending<=1. Writes to i_cfg_ch>=NUM_CH are ignored.
- Write in the same cycle as that channel's boundary: the written value bypasses the shadow and becomes active at that boundary, and pending stays 0.
- Write to a non-running channel: applied to active registers immediately, pending stays 0.
- Write while pending: overwrites the shadow; only the last write is applied.
- i_sync: every running channel sets cnt<=0 and o_clk_div<=(duty_act'>0), where duty_act' includes any pending config, which is applied and cleared. Non-running channels are unaffected.
- Priority per channel: reset > disable > sync > boundary > count.
- Arithmetic is unsigned CNT_W. The counter wraps only via the boundary compare and never overflows, since cnt<div_act.

Optional Feature:
- Macro DIVIDER_TICK_EN.
- Defined: adds output o_tick [NUM_CH], a registered single-cycle pulse asserted in the first cycle of each period. That covers the start cycle, every cycle after a boundary, and the cycle after an i_sync restart. It is low when the channel is not running. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, i_en=4'b0001, defaults 16/4 -> ch0 high 4 cycles, low 12, period 16. Other channels stay 0; o_cfg_pending=0.
- Write ch0 div=10, duty=5 at cnt=7 -> pending[0]=1 until the boundary. The current period completes 16/4, then periods become 10/5 and pending clears.
- Write ch1 div=6, duty=6 then div=6, duty=0 while the channel is disabled, then enable -> constant low (last write wins). Rewrite with duty=6 at a boundary -> constant high from the next period.
- Write arriving exactly in the boundary cycle (cnt=15) for ch0 div=8, duty=2 -> the very next period is 8/2; pending is never asserted.
- Channels 0 and 2 running at different phases, pulse i_sync -> both restart at cnt=0 on the same edge with rising outputs aligned. Deassert i_en[2] mid-high -> o_clk_div[2]=0 on the next cycle.
- Assert i_rst mid-period with pending=1 -> outputs 0 immediately (asynchronous), pending cleared, defaults restored. With DIVIDER_TICK_EN, o_tick pulses once per 16 cycles after re-enable.
